fibgy_responder: RTL and testbench

Fiber-gyro side responder for the gyro UART link, facing the CoreUART byte interface (DATA_OUT/RXRDY/OEN, DATA_IN/TXRDY/WEN).
- Pops command bytes from the UART and decodes the request command.
- Answers each valid request with a fixed 8-byte telemetry frame carrying a snapshot of ANGLE and STATUS.
- Used as a gyro emulator on the interface board and in system benches, opposite FIBERGYRO_control.

---
 rtl/fibgy_pkg.sv | 24 ++
 rtl/fibgy_frame_mux.sv | 30 +++
 rtl/fibgy_responder.sv | 158 +++++++++++++++
 tb/tb_fibgy_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fibgy_pkg.sv
// Shared types and constants for the fiber-gyro UART responder.
package fibgy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RGUARD,
    DECODE,
    LOAD,
    WRITE,
    WGUARD
  } state_t;

  localparam int         FRAME_LEN   = 8;
  localparam int         GUARD_DEF   = 2;
  localparam logic [7:0] CMD_REQ_DEF = 8'hA5;
  localparam logic [7:0] HDR0_DEF    = 8'hEB;
  localparam logic [7:0] HDR1_DEF    = 8'h90;

  // Running mod-256 checksum step.
  function automatic logic [7:0] chk8(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/fibgy_frame_mux.sv
// Selects the telemetry frame byte for a given index from the snapshot and checksum.
module fibgy_frame_mux
  import fibgy_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic [2:0]  idx,
  input  logic [31:0] angle,
  input  logic [7:0]  status,
  input  logic [7:0]  chk,
  output logic [7:0]  data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      3'd0: data = HDR0;
      3'd1: data = HDR1;
      3'd2: data = angle[31:24];
      3'd3: data = angle[23:16];
      3'd4: data = angle[15:8];
      3'd5: data = angle[7:0];
      3'd6: data = status;
      3'd7: data = chk;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/fibgy_responder.sv
// Gyro emulator: reads request bytes from a CoreUART and answers each valid
// request with an 8-byte ANGLE/STATUS telemetry frame.
module fibgy_responder
  import fibgy_pkg::*;
#(
  parameter logic [7:0] CMD_REQ = CMD_REQ_DEF,
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter int         GUARD   = GUARD_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [7:0]  RX_DATA,
  input  logic        RXRDY,
  output logic        OEN,
  output logic [7:0]  TX_DATA,
  input  logic        TXRDY,
  output logic        WEN,
  input  logic [31:0] ANGLE,
  input  logic [7:0]  STATUS,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic [7:0]  ERR_CNT,
  output state_t      STATE_DBG
);

  // UART handshake: RXRDY/TXRDY are levels. A read is one cycle of OEN=0
  // (RX_DATA latched on the edge that raises it), a write is one cycle of
  // WEN=0 with TX_DATA stable; after either strobe the matching ready level
  // is ignored for GUARD cycles while the UART updates it.
  localparam logic [3:0] GUARD_M1 = 4'(GUARD - 1);
  localparam logic [3:0] GUARD_W  = 4'(GUARD);

  state_t      state, state_d;
  logic [3:0]  guard_cnt, drop_cnt;
  logic [2:0]  idx;
  logic [7:0]  rx_byte, status_q, chk_acc, frame_byte;
  logic [31:0] angle_q;
  logic        guard_done, drop_ok;
  logic        read_req, drop_req, accept, bad_cmd, load_fire, write_fire;

  assign STATE_DBG  = state;
  assign guard_done = (guard_cnt == 4'd0);
  assign drop_ok    = BUSY && RXRDY && (drop_cnt == 4'd0);

  fibgy_frame_mux #(.HDR0(HDR0), .HDR1(HDR1)) u_mux (
    .idx    (idx),
    .angle  (angle_q),
    .status (status_q),
    .chk    (chk_acc),
    .data   (frame_byte)
  );

  always_comb begin
    state_d    = state;
    read_req   = 1'b0;
    drop_req   = 1'b0;
    accept     = 1'b0;
    bad_cmd    = 1'b0;
    load_fire  = 1'b0;
    write_fire = 1'b0;
    case (state)
      IDLE: begin
        if (RXRDY && (drop_cnt == 4'd0)) begin
          read_req = 1'b1;
          state_d  = RGUARD;
        end
      end
      RGUARD: if (guard_done) state_d = DECODE;
      DECODE: begin
        if (!ENABLE) begin
          state_d = IDLE;
        end else if (rx_byte == CMD_REQ) begin
          accept  = 1'b1;
          state_d = LOAD;
        end else begin
          bad_cmd = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        // A pending write wins; a waiting read is serviced in a later slot.
        if (TXRDY) begin
          load_fire = 1'b1;
          state_d   = WRITE;
        end else if (drop_ok) begin
          drop_req = 1'b1;
        end
      end
      WRITE: begin
        write_fire = 1'b1;
        state_d    = WGUARD;
      end
      WGUARD: begin
        if (guard_done) begin
          drop_req = drop_ok;
          state_d  = (idx == 3'd7) ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      guard_cnt  <= 4'd0;
      drop_cnt   <= 4'd0;
      idx        <= 3'd0;
      rx_byte    <= 8'h00;
      angle_q    <= 32'h0;
      status_q   <= 8'h00;
      chk_acc    <= 8'h00;
      OEN        <= 1'b1;
      WEN        <= 1'b1;
      TX_DATA    <= 8'h00;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR_CNT    <= 8'h00;
    end else begin
      state      <= state_d;
      OEN        <= !(read_req || drop_req);
      WEN        <= !write_fire;
      FRAME_DONE <= write_fire && (idx == 3'd7);

      if (read_req) rx_byte <= RX_DATA;

      if (read_req || write_fire) guard_cnt <= GUARD_M1;
      else if (!guard_done)       guard_cnt <= guard_cnt - 4'd1;

      if (drop_req)               drop_cnt <= GUARD_W;
      else if (drop_cnt != 4'd0)  drop_cnt <= drop_cnt - 4'd1;

      if ((bad_cmd || drop_req) && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;

      if (accept) begin
        angle_q  <= ANGLE;
        status_q <= STATUS;
        chk_acc  <= 8'h00;
        idx      <= 3'd0;
        BUSY     <= 1'b1;
      end

      // Checksum covers the payload bytes 2..6 as they are loaded.
      if (load_fire) begin
        TX_DATA <= frame_byte;
        if ((idx >= 3'd2) && (idx <= 3'd6)) chk_acc <= chk8(chk_acc, frame_byte);
      end

      if ((state == WGUARD) && guard_done) begin
        if (idx == 3'd7) BUSY <= 1'b0;
        else             idx  <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fibgy_responder.sv
// Directed bench for fibgy_responder with a UART-side driver and a TX byte scoreboard.
module tb_fibgy_responder;
  import fibgy_pkg::*;

  logic        clk = 1'b0;
  logic        RESET, ENABLE, RXRDY, TXRDY;
  logic [7:0]  RX_DATA, TX_DATA, STATUS, ERR_CNT;
  logic [31:0] ANGLE;
  logic        OEN, WEN, BUSY, FRAME_DONE;
  state_t      STATE_DBG;

  logic [7:0] exp_q[$];
  int total = 0, bad = 0;
  int oen_cnt = 0, wen_cnt = 0, fd_cnt = 0, cyc = 0;
  int oen_cyc = 0, first_wen_cyc = 0;
  logic [2:0] mon_idx = 3'd0;

  fibgy_responder dut (
    .CLK        (clk),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .RX_DATA    (RX_DATA),
    .RXRDY      (RXRDY),
    .OEN        (OEN),
    .TX_DATA    (TX_DATA),
    .TXRDY      (TXRDY),
    .WEN        (WEN),
    .ANGLE      (ANGLE),
    .STATUS     (STATUS),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .ERR_CNT    (ERR_CNT),
    .STATE_DBG  (STATE_DBG)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (RESET === 1'b0) begin
      if (OEN === 1'b0) begin
        oen_cnt++;
        oen_cyc = cyc;
      end
      if (WEN === 1'b0) begin
        wen_cnt++;
        if (mon_idx == 3'd0) first_wen_cyc = cyc;
        if (exp_q.size() == 0) check("tx_unexpected", 32'(exp_q.size()), 32'd1);
        else                   check("tx_byte", 32'(TX_DATA), 32'(exp_q.pop_front()));
        check("frame_done", 32'(FRAME_DONE), 32'(mon_idx == 3'd7));
        check("busy_in_frame", 32'(BUSY), 32'd1);
        mon_idx = mon_idx + 3'd1;
      end else if (FRAME_DONE === 1'b1) begin
        check("frame_done_alone", 32'(FRAME_DONE), 32'd0);
      end
      if (FRAME_DONE === 1'b1) fd_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    int start = oen_cnt;
    tick();
    RX_DATA = b;
    RXRDY   = 1'b1;
    while (oen_cnt == start && n < 200) begin
      tick();
      n++;
    end
    if (oen_cnt == start) check("oen_timeout", 32'(oen_cnt - start), 32'd1);
    RXRDY = 1'b0;
  endtask

  task automatic wait_wen(input int target);
    int n = 0;
    while (wen_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    if (wen_cnt < target) check("wen_timeout", 32'(wen_cnt), 32'(target));
  endtask

  task automatic wait_frame(input int start);
    int n = 0;
    while (fd_cnt == start && n < 2000) begin
      tick();
      n++;
    end
    if (fd_cnt == start) check("frame_timeout", 32'(fd_cnt - start), 32'd1);
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) exp_q.push_back(f[i*8 +: 8]);
  endtask

  int base_wen, base_oen, base_fd, lat_oen;
  logic [7:0] base_err;

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; RXRDY = 1'b0; TXRDY = 1'b1;
    RX_DATA = 8'h00; ANGLE = 32'h12345678; STATUS = 8'h01;
    ticks(3);
    RESET = 1'b0;
    check("rst_oen",   32'(OEN), 32'd1);
    check("rst_wen",   32'(WEN), 32'd1);
    check("rst_txd",   32'(TX_DATA), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    check("rst_fd",    32'(FRAME_DONE), 32'd0);
    check("rst_err",   32'(ERR_CNT), 32'd0);
    check("rst_state", 32'(STATE_DBG), 32'(IDLE));

    // basic frame and minimum latency
    base_fd = fd_cnt;
    push_frame(64'hEB90_1234_5678_0115);
    send_byte(8'hA5);
    lat_oen = oen_cyc;
    wait_frame(base_fd);
    check("latency", 32'(first_wen_cyc - lat_oen), 32'd5);
    ticks(4);
    check("busy_after", 32'(BUSY), 32'd0);

    // unknown command
    base_wen = wen_cnt; base_oen = oen_cnt;
    send_byte(8'h3C);
    ticks(20);
    check("bad_oen", 32'(oen_cnt - base_oen), 32'd1);
    check("bad_nowen", 32'(wen_cnt - base_wen), 32'd0);
    check("bad_err", 32'(ERR_CNT), 32'd1);

    // disabled: byte read and discarded without counting
    ENABLE = 1'b0;
    base_wen = wen_cnt; base_oen = oen_cnt;
    send_byte(8'hA5);
    ticks(20);
    ENABLE = 1'b1;
    check("dis_oen", 32'(oen_cnt - base_oen), 32'd1);
    check("dis_nowen", 32'(wen_cnt - base_wen), 32'd0);
    check("dis_err", 32'(ERR_CNT), 32'd1);

    // second request during byte 3 is dropped and counted
    base_wen = wen_cnt; base_oen = oen_cnt; base_fd = fd_cnt;
    push_frame(64'hEB90_1234_5678_0115);
    send_byte(8'hA5);
    wait_wen(base_wen + 3);
    send_byte(8'hA5);
    wait_frame(base_fd);
    ticks(60);
    check("drop_err", 32'(ERR_CNT), 32'd2);
    check("drop_oen", 32'(oen_cnt - base_oen), 32'd2);
    check("drop_wen", 32'(wen_cnt - base_wen), 32'd8);
    check("drop_busy", 32'(BUSY), 32'd0);

    // TXRDY stall before byte 4
    ANGLE = 32'h80FF017F; STATUS = 8'h5A;
    base_wen = wen_cnt; base_fd = fd_cnt;
    push_frame(64'hEB90_80FF_017F_5A59);
    send_byte(8'hA5);
    wait_wen(base_wen + 4);
    TXRDY = 1'b0;
    ticks(50);
    check("stall_wen", 32'(wen_cnt - base_wen), 32'd4);
    check("stall_txd", 32'(TX_DATA), 32'hFF);
    check("stall_busy", 32'(BUSY), 32'd1);
    TXRDY = 1'b1;
    wait_frame(base_fd);
    ticks(4);

    // snapshot isolation
    ANGLE = 32'h12345678; STATUS = 8'h01;
    base_wen = wen_cnt; base_fd = fd_cnt;
    push_frame(64'hEB90_1234_5678_0115);
    send_byte(8'hA5);
    wait_wen(base_wen + 1);
    ANGLE = 32'hFFFFFFFF; STATUS = 8'hFF;
    wait_frame(base_fd);
    ticks(4);

    // ERR_CNT saturation
    for (int i = 0; i < 252; i++) send_byte((i % 2 == 0) ? 8'h3C : 8'h00);
    ticks(6);
    check("err_254", 32'(ERR_CNT), 32'd254);
    send_byte(8'h5A);
    ticks(6);
    check("err_255", 32'(ERR_CNT), 32'd255);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    ticks(6);
    check("err_sat", 32'(ERR_CNT), 32'd255);

    // reset mid-frame at byte 5
    ANGLE = 32'h12345678; STATUS = 8'h01;
    base_wen = wen_cnt;
    push_frame(64'hEB90_1234_5678_0115);
    send_byte(8'hA5);
    wait_wen(base_wen + 5);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_q.delete();
    mon_idx = 3'd0;
    check("mid_rst_wen", 32'(WEN), 32'd1);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_err", 32'(ERR_CNT), 32'd0);
    check("mid_rst_state", 32'(STATE_DBG), 32'(IDLE));
    base_wen = wen_cnt;
    ticks(30);
    check("mid_rst_nowen", 32'(wen_cnt - base_wen), 32'd0);

    // fresh frame after reset
    ANGLE = 32'hDEADBEEF; STATUS = 8'h80;
    base_wen = wen_cnt; base_fd = fd_cnt;
    push_frame(64'hEB90_DEAD_BEEF_80B8);
    send_byte(8'hA5);
    wait_frame(base_fd);
    ticks(4);
    check("post_rst_wen", 32'(wen_cnt - base_wen), 32'd8);
    check("exp_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
